// File: rtl/song_note_reader.sv
// ---------------------------------------------------------------------------
// song_note_reader
//
// Reads a song, one word per note, from a song FIFO and presents the note
// that is currently being scored. Each word holds a note code in bits
// [NOTE_W+DUR_W-1:DUR_W] and a duration in beat ticks in bits [DUR_W-1:0].
// A word with duration 0 marks the end of the song.
//
// Optional feature: define NOTE_GAP_EN to insert a silent gap of one beat
// tick between consecutive notes (adds the GAP state). With the macro
// undefined the reader goes straight from PLAY to FETCH.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous, active-low reset
//   start        in   one-cycle pulse, begins playback from IDLE or DONE
//   stop         in   one-cycle pulse, aborts playback (beats start and tick)
//   tick         in   one-cycle beat tick, paces the duration countdown
//   fifo_empty   in   song FIFO empty flag
//   fifo_valid   in   song FIFO read data valid
//   fifo_dout    in   song FIFO read data
//   fifo_rd_en   out  song FIFO read enable
//   note_code    out  current target note (0 = rest), holds its last value
//   note_valid   out  note_code is the note currently being scored
//   busy         out  playback in progress (state is not IDLE or DONE)
//   starved      out  FIFO is empty while a fetch is pending
//   song_done    out  end-of-song marker reached
//   notes_played out  notes loaded since the last start (saturating)
// ---------------------------------------------------------------------------
module song_note_reader #(
  parameter int DATA_W = 15,
  parameter int NOTE_W = 7,
  parameter int DUR_W  = 8,
  parameter int CNT_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              tick,
  input  logic              fifo_empty,
  input  logic              fifo_valid,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic [NOTE_W-1:0] note_code,
  output logic              note_valid,
  output logic              busy,
  output logic              starved,
  output logic              song_done,
  output logic [CNT_W-1:0]  notes_played
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_PLAY  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
`ifdef NOTE_GAP_EN
  localparam logic [2:0] ST_GAP   = 3'd5;
`endif

  localparam logic [DUR_W-1:0]  DUR_ZERO = {DUR_W{1'b0}};
  localparam logic [DUR_W-1:0]  DUR_ONE  = {{(DUR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [NOTE_W-1:0] NOTE_ZERO = {NOTE_W{1'b0}};

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [DUR_W-1:0]  r_count;
  logic [NOTE_W-1:0] r_note_code;
  logic [CNT_W-1:0]  r_notes_played;
  logic              r_song_done;
  logic              r_note_valid;
  logic              r_busy;

  logic [DUR_W-1:0]  w_dur;
  logic [NOTE_W-1:0] w_note;
  logic              w_idle_or_done;
  logic              w_capture;
  logic              w_last_tick;

  assign w_dur          = fifo_dout[DUR_W-1:0];
  assign w_note         = fifo_dout[DUR_W +: NOTE_W];
  assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);
  // A word is only taken in WAIT; a word arriving together with stop is dropped.
  assign w_capture      = (r_state == ST_WAIT) && fifo_valid && !stop;
  // The tick that takes the countdown from 1 to 0 ends the note.
  assign w_last_tick    = (r_state == ST_PLAY) && tick && (r_count == DUR_ONE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; stop overrides every other input.
  always_comb begin
    w_next = r_state;
    if (stop) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            w_next = ST_FETCH;
          end else begin
            w_next = r_state;
          end
        end
        ST_FETCH: begin
          if (!fifo_empty) begin
            w_next = ST_WAIT;
          end else begin
            w_next = ST_FETCH;
          end
        end
        ST_WAIT: begin
          if (fifo_valid) begin
            if (w_dur == DUR_ZERO) begin
              w_next = ST_DONE;
            end else begin
              w_next = ST_PLAY;
            end
          end else begin
            w_next = ST_WAIT;
          end
        end
        ST_PLAY: begin
          if (w_last_tick) begin
`ifdef NOTE_GAP_EN
            w_next = ST_GAP;
`else
            w_next = ST_FETCH;
`endif
          end else begin
            w_next = ST_PLAY;
          end
        end
`ifdef NOTE_GAP_EN
        ST_GAP: begin
          // Silence lasts until the next beat tick.
          if (tick) begin
            w_next = ST_FETCH;
          end else begin
            w_next = ST_GAP;
          end
        end
`endif
        default: begin
          w_next = ST_IDLE;
        end
      endcase
    end
  end

  // FIFO handshake outputs; the read strobe must follow fifo_empty in the
  // same cycle so it can never fire on an empty FIFO.
  always_comb begin
    fifo_rd_en = 1'b0;
    starved    = 1'b0;
    if (r_state == ST_FETCH) begin
      fifo_rd_en = !fifo_empty && !stop;
      starved    = fifo_empty;
    end else begin
      fifo_rd_en = 1'b0;
      starved    = 1'b0;
    end
  end

  // Status flags registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_note_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_note_valid <= (w_next == ST_PLAY);
      r_busy       <= (w_next != ST_IDLE) && (w_next != ST_DONE);
    end
  end

  // Note datapath: countdown, note code, played counter and end-of-song flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count        <= DUR_ZERO;
      r_note_code    <= NOTE_ZERO;
      r_notes_played <= CNT_ZERO;
      r_song_done    <= 1'b0;
    end else if (stop) begin
      r_count     <= DUR_ZERO;
      r_song_done <= 1'b0;
    end else if (start && w_idle_or_done) begin
      r_notes_played <= CNT_ZERO;
      r_song_done    <= 1'b0;
    end else if (w_capture) begin
      if (w_dur == DUR_ZERO) begin
        r_song_done <= 1'b1;
      end else begin
        r_count     <= w_dur;
        r_note_code <= w_note;
        if (r_notes_played != CNT_MAX) begin
          r_notes_played <= r_notes_played + CNT_ONE;
        end else begin
          r_notes_played <= r_notes_played;
        end
      end
    end else if ((r_state == ST_PLAY) && tick) begin
      r_count <= r_count - DUR_ONE;
    end else begin
      r_count <= r_count;
    end
  end

  assign note_code    = r_note_code;
  assign note_valid   = r_note_valid;
  assign busy         = r_busy;
  assign song_done    = r_song_done;
  assign notes_played = r_notes_played;

endmodule

// File: tb/tb_song_note_reader.sv
module tb_song_note_reader;

  typedef struct {
    logic [14:0] word;
    int          exp_note;
    int          exp_dur;
  } vec_t;

  typedef struct {
    int note;
    int dur;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        tick;
  logic        fifo_empty;
  logic        fifo_valid;
  logic [14:0] fifo_dout;
  logic        fifo_rd_en;
  logic [6:0]  note_code;
  logic        note_valid;
  logic        busy;
  logic        starved;
  logic        song_done;
  logic [11:0] notes_played;

  song_note_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .tick         (tick),
    .fifo_empty   (fifo_empty),
    .fifo_valid   (fifo_valid),
    .fifo_dout    (fifo_dout),
    .fifo_rd_en   (fifo_rd_en),
    .note_code    (note_code),
    .note_valid   (note_valid),
    .busy         (busy),
    .starved      (starved),
    .song_done    (song_done),
    .notes_played (notes_played)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [14:0] song_q[$];
  exp_t        exp_q[$];
  logic        hold_empty = 1'b0;
  int          tick_period = 2;
  int          cyc_n = 0;
  int          rd_cnt = 0;
  int          rd_empty_viol = 0;
  logic        rd_seen = 1'b0;
  logic        rd_viol = 1'b0;
  logic        prev_nv = 1'b0;
  logic        aborted = 1'b0;
  int          cur_ticks = 0;
  int          exp_dur = 0;
  int          gap_cycles = 0;
  int          gap_ticks = 0;
  int          last_gap_cycles = 0;
  int          last_gap_ticks = 0;
  vec_t        vecs[5];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Read strobes as the DUT presents them at the clock edge.
  always @(posedge clk) begin
    rd_seen <= fifo_rd_en;
    rd_viol <= fifo_rd_en && fifo_empty;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: observe outputs, run the scoreboard and FIFO model, drive tick.
  task automatic step();
    exp_t e;
    @(negedge clk);
    cyc_n++;
    if (note_valid && !prev_nv) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_note: got note %0d, expected no note", note_code);
      end else begin
        e = exp_q.pop_front();
        check("note_code", int'(note_code), e.note);
        exp_dur = e.dur;
      end
      cur_ticks       = 0;
      last_gap_cycles = gap_cycles;
      last_gap_ticks  = gap_ticks;
    end
    if (!note_valid && prev_nv) begin
      if (!aborted) check("note_ticks", cur_ticks, exp_dur);
      gap_cycles = 0;
      gap_ticks  = 0;
    end
    if (!note_valid && busy) gap_cycles++;
    prev_nv = note_valid;
    fifo_valid = 1'b0;
    if (rd_seen) begin
      rd_cnt++;
      if (rd_viol) begin
        rd_empty_viol++;
      end else if (song_q.size() > 0) begin
        fifo_dout  = song_q.pop_front();
        fifo_valid = 1'b1;
      end
    end
    fifo_empty = hold_empty || (song_q.size() == 0);
    tick = (tick_period > 0) && ((cyc_n % tick_period) == 0);
    if (tick && note_valid) cur_ticks++;
    if (tick && !note_valid && busy) gap_ticks++;
  endtask

  task automatic pulse_start();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget, input string name);
    int n = 0;
    while (!song_done && n < budget) begin
      step();
      n++;
    end
    check(name, int'(song_done), 1);
  endtask

  task automatic wait_nv(input int budget, input string name);
    int n = 0;
    while (!note_valid && n < budget) begin
      step();
      n++;
    end
    check(name, int'(note_valid), 1);
  endtask

  initial begin
    int base;
    int cnt;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
    fifo_valid = 1'b0; fifo_dout = 15'd0; fifo_empty = 1'b1;
    #1;
    check("rst_rd_en", int'(fifo_rd_en), 0);
    check("rst_note_valid", int'(note_valid), 0);
    check("rst_note_code", int'(note_code), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_starved", int'(starved), 0);
    check("rst_song_done", int'(song_done), 0);
    check("rst_notes_played", int'(notes_played), 0);
    repeat (3) step();
    rst_n = 1'b1;

    // Table-driven song: each record is a word with its expected note and length.
    vecs[0] = '{15'h0A03, 10, 3};
    vecs[1] = '{15'h7F01, 127, 1};
    vecs[2] = '{15'h00FF, 0, 255};
    vecs[3] = '{15'h2C07, 44, 7};
    vecs[4] = '{15'h7FFF, 127, 255};
    tick_period = 2;
    base = rd_cnt;
    for (int i = 0; i < 5; i++) begin
      song_q.push_back(vecs[i].word);
      exp_q.push_back('{vecs[i].exp_note, vecs[i].exp_dur});
    end
    song_q.push_back(15'd0);
    pulse_start();
    run_until_done(4000, "table_done");
    check("table_notes_played", int'(notes_played), 5);
    check("table_rd_count", rd_cnt - base, 6);
    check("table_sb_drained", exp_q.size(), 0);
    check("table_busy_after", int'(busy), 0);

    // Single note 481 = note 1, 225 ticks, then end marker.
    tick_period = 1;
    base = rd_cnt;
    song_q.push_back(15'd481);
    song_q.push_back(15'd0);
    exp_q.push_back('{1, 225});
    pulse_start();
    run_until_done(1000, "single_done");
    check("single_rd_count", rd_cnt - base, 2);
    check("single_notes_played", int'(notes_played), 1);
    check("single_note_valid", int'(note_valid), 0);

    // Starvation: FIFO held empty for 20 cycles after start.
    tick_period = 2;
    hold_empty = 1'b1;
    song_q.push_back(15'h0101);
    song_q.push_back(15'd0);
    exp_q.push_back('{1, 1});
    base = rd_cnt;
    pulse_start();
    check("starve_done_cleared", int'(song_done), 0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (starved) cnt++;
    end
    check("starve_cycles", cnt, 20);
    check("starve_no_rd", rd_cnt - base, 0);
    hold_empty = 1'b0;
    fifo_empty = 1'b0;
    #1;
    check("starve_release_rd", int'(fifo_rd_en), 1);
    check("starve_release_flag", int'(starved), 0);
    run_until_done(100, "starve_done");
    check("starve_rd_count", rd_cnt - base, 2);
    check("starve_notes_played", int'(notes_played), 1);

    // Abort: stop during 0x0105 after two ticks.
    song_q.push_back(15'h0105);
    song_q.push_back(15'h0202);
    song_q.push_back(15'd0);
    exp_q.push_back('{1, 5});
    pulse_start();
    wait_nv(20, "abort_note_start");
    cnt = 0;
    while (cur_ticks < 2 && cnt < 20) begin
      step();
      cnt++;
    end
    step();
    aborted = 1'b1;
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("abort_note_valid", int'(note_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_song_done", int'(song_done), 0);
    base = rd_cnt;
    repeat (20) step();
    check("abort_no_rd", rd_cnt - base, 0);
    check("abort_still_idle", int'(busy), 0);
    song_q.delete();
    exp_q.delete();
    aborted = 1'b0;

    // Stop while the fetched word is in flight: the word is discarded.
    song_q.push_back(15'h0103);
    song_q.push_back(15'd0);
    pulse_start();
    base = rd_cnt;
    cnt = 0;
    while (rd_cnt == base && cnt < 10) begin
      step();
      cnt++;
    end
    check("discard_rd", rd_cnt - base, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (note_valid) cnt++;
    end
    check("discard_no_note", cnt, 0);
    check("discard_notes_played", int'(notes_played), 0);
    song_q.delete();

    // Gap between two notes.
    tick_period = 3;
    song_q.push_back(15'h0202);
    song_q.push_back(15'h0301);
    song_q.push_back(15'd0);
    exp_q.push_back('{2, 2});
    exp_q.push_back('{3, 1});
    pulse_start();
    run_until_done(200, "gap_done");
`ifdef NOTE_GAP_EN
    check("gap_low_cycles", last_gap_cycles, 5);
    check("gap_low_ticks", last_gap_ticks, 1);
`else
    check("gap_low_cycles", last_gap_cycles, 2);
    check("gap_low_ticks", last_gap_ticks, 0);
`endif

    // Saturation of the played counter.
    tick_period = 1;
    for (int i = 0; i < 4100; i++) begin
      song_q.push_back(15'h0101);
      exp_q.push_back('{1, 1});
    end
    song_q.push_back(15'd0);
    pulse_start();
    run_until_done(25000, "sat_done");
    check("sat_notes_played", int'(notes_played), 4095);

    // Reset asserted in the middle of a note.
    tick_period = 2;
    song_q.push_back(15'h0110);
    song_q.push_back(15'd0);
    exp_q.push_back('{1, 16});
    pulse_start();
    check("restart_clears_count", int'(notes_played), 0);
    wait_nv(20, "rstmid_note_start");
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_rd_en", int'(fifo_rd_en), 0);
    check("rstmid_note_valid", int'(note_valid), 0);
    check("rstmid_note_code", int'(note_code), 0);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_starved", int'(starved), 0);
    check("rstmid_song_done", int'(song_done), 0);
    check("rstmid_notes_played", int'(notes_played), 0);
    aborted = 1'b1;
    song_q.delete();
    exp_q.delete();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();
    aborted = 1'b0;

    check("no_rd_when_empty", rd_empty_viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
